// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_pkg
//  Purpose  : Shared types and constants for the data-memory responder:
//             FSM state encoding, storage geometry and default timing.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    localparam int DMEM_ADDR_WIDTH = 7;
    localparam int DMEM_DATA_WIDTH = 32;
    localparam int DMEM_WORDS      = 32;
    localparam int DMEM_LATENCY    = 2;
    // Wide enough for the largest legal latency (15).
    localparam int DMEM_CNT_WIDTH  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    // Any set bit below the word boundary marks a misaligned access.
    function automatic logic is_misaligned(input logic [1:0] byte_offset);
        return |byte_offset;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_array
//  Purpose  : Word storage for the data-memory responder. Combinational
//             read port, synchronous write port. Contents are never reset.
//  Ports    : clk   - clock, write on posedge
//             we    - write enable
//             widx  - write word index
//             wdata - write data
//             ridx  - read word index
//             rdata - read data (combinational)
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_array #(
    parameter int WORDS      = 32,
    parameter int IDX_WIDTH  = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [IDX_WIDTH-1:0]  widx,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [IDX_WIDTH-1:0]  ridx,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] r_mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[widx] <= wdata;
        end
    end

    assign rdata = r_mem[ridx];

endmodule
`default_nettype wire

// File: rtl/data_memory_responder.sv
`default_nettype none
// ============================================================================
//  Module   : data_memory_responder
//  Purpose  : Handshaked, fixed-latency data-memory model for the MEM stage.
//             A request is accepted in IDLE, waits LATENCY-1 cycles in WAIT,
//             then RESP pulses Resp_Valid for one cycle and commits any write.
//  Ports    : Clk, Reset (async, active-high)
//             Req_Valid/Req_Read/Req_Write/Req_Address/Req_WData - request
//             Req_Ready  - high in IDLE only
//             Resp_Valid - one-cycle completion pulse
//             Resp_RData - read data, zero whenever Resp_Valid is low
//             Resp_Err   - misaligned-access flag, zero unless trapping
//  Config   : define DMEM_MISALIGN_TRAP_EN to flag misaligned accesses
//             (Resp_Err=1, write suppressed, RData=0); otherwise the low
//             address bits are ignored and Resp_Err is always 0.
//  Revision : 1.0 - initial release
// ============================================================================
module data_memory_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = DMEM_ADDR_WIDTH,
    parameter int DATA_WIDTH = DMEM_DATA_WIDTH,
    parameter int LATENCY    = DMEM_LATENCY
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Req_Valid,
    input  logic                  Req_Read,
    input  logic                  Req_Write,
    input  logic [ADDR_WIDTH-1:0] Req_Address,
    input  logic [DATA_WIDTH-1:0] Req_WData,
    output logic                  Req_Ready,
    output logic                  Resp_Valid,
    output logic [DATA_WIDTH-1:0] Resp_RData,
    output logic                  Resp_Err
);

    localparam int IDX_WIDTH = ADDR_WIDTH - 2;
    localparam int WORDS     = 1 << IDX_WIDTH;
    localparam logic [DMEM_CNT_WIDTH-1:0] c_cnt_load = DMEM_CNT_WIDTH'(LATENCY - 1);

    dmem_state_t               r_state;
    dmem_state_t               w_next_state;
    logic [DMEM_CNT_WIDTH-1:0] r_cnt;
    logic [DMEM_CNT_WIDTH-1:0] w_next_cnt;

    // Transaction holding registers, captured at acceptance.
    logic [IDX_WIDTH-1:0]  r_widx;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_read;
    logic                  r_write;
    logic                  r_misalign;

    logic                  w_accept;
    logic                  w_misalign;
    logic                  w_resp;
    logic                  w_array_we;
    logic [DATA_WIDTH-1:0] w_array_rdata;

    assign w_accept = (r_state == IDLE) && Req_Valid;
    assign w_resp   = (r_state == RESP);

`ifdef DMEM_MISALIGN_TRAP_EN
    assign w_misalign = is_misaligned(Req_Address[1:0]);
`else
    // Byte offset is ignored; folding it into a constant zero keeps the
    // bits visibly consumed without affecting the access.
    assign w_misalign = &{1'b0, Req_Address[1:0]};
`endif

    // Commit happens only on the RESP -> IDLE edge, so a reset during WAIT
    // can never corrupt the array.
    assign w_array_we = w_resp && r_write && !r_misalign;

    dmem_array #(
        .WORDS      (WORDS),
        .IDX_WIDTH  (IDX_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_array (
        .clk   (Clk),
        .we    (w_array_we),
        .widx  (r_widx),
        .wdata (r_wdata),
        .ridx  (Req_Address[ADDR_WIDTH-1:2]),
        .rdata (w_array_rdata)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (Req_Valid) begin
                    if (LATENCY == 1) begin
                        w_next_state = RESP;
                    end else begin
                        w_next_state = WAIT;
                        w_next_cnt   = c_cnt_load;
                    end
                end
            end
            WAIT: begin
                w_next_cnt = r_cnt - 1'b1;
                // <= also recovers from a zero count rather than wrapping.
                if (r_cnt <= 1) begin
                    w_next_state = RESP;
                end
            end
            RESP: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
                w_next_cnt   = '0;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_widx     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_read     <= 1'b0;
            r_write    <= 1'b0;
            r_misalign <= 1'b0;
        end else if (w_accept) begin
            r_widx     <= Req_Address[ADDR_WIDTH-1:2];
            r_wdata    <= Req_WData;
            r_rdata    <= w_array_rdata;
            r_read     <= Req_Read;
            r_write    <= Req_Write;
            r_misalign <= w_misalign;
        end
    end

    assign Req_Ready  = (r_state == IDLE);
    assign Resp_Valid = w_resp;
    assign Resp_Err   = w_resp && r_misalign;
    assign Resp_RData = (w_resp && r_read && !r_misalign) ? r_rdata : '0;

endmodule
`default_nettype wire
